// File: rtl/exp_unit_scheduler_if.sv
// Bundles the requester-side handshake and the exponent-unit bus of exp_unit_scheduler.
// The slave modport is the scheduler; the master modport is the requesters plus exponent unit.
interface exp_unit_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_x;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          rsp_err;
  logic                          busy;
  logic [DATA_WIDTH-1:0]         exp_x;
  logic                          exp_enable;
  logic [DATA_WIDTH-1:0]         exp_out;
  logic                          exp_ack;

  modport slave (
    input  req_valid, req_x, exp_out, exp_ack,
    output req_ready, rsp_valid, rsp_data, rsp_err, busy, exp_x, exp_enable
  );

  modport master (
    output req_valid, req_x, exp_out, exp_ack,
    input  req_ready, rsp_valid, rsp_data, rsp_err, busy, exp_x, exp_enable
  );
endinterface

// File: rtl/exp_unit_scheduler.sv
// Round-robin scheduler sharing one exponent unit among NUM_REQ requesters, one job at a time.
// Optional RUN watchdog enabled by defining EXP_TIMEOUT_EN.
module exp_unit_scheduler #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                 clk,
  input  logic                 reset_n,
  exp_unit_scheduler_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]     req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   busy_q, busy_d;
  logic [DATA_WIDTH-1:0]  exp_x_q, exp_x_d;
  logic                   exp_enable_q, exp_enable_d;

`ifdef EXP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]       tmo_cnt_q, tmo_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  logic                   grant_vld;
  logic [IDX_W-1:0]       grant_idx;
  logic [DATA_WIDTH-1:0]  grant_x;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  // Search starts just after the last grant, so the previous winner has lowest priority.
  always_comb begin
    int cand;
    grant_vld = 1'b0;
    grant_idx = rr_ptr_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant_vld && bus.req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
    grant_x = bus.req_x[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
  end

  // NOTE: every _d signal is given its hold/idle value first, so no latch can be inferred.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    exp_x_d     = exp_x_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = 1'b0;
    req_ready_d = '0;
    rsp_valid_d = '0;
`ifdef EXP_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (grant_vld) begin
          state_d     = S_LOAD;
          rr_ptr_d    = grant_idx;
          exp_x_d     = grant_x;
          req_ready_d = onehot(grant_idx);
        end
      end
      S_LOAD: begin
        state_d = S_RUN;
`ifdef EXP_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      S_RUN: begin
        if (bus.exp_ack) begin
          state_d     = S_DONE;
          rsp_data_d  = bus.exp_out;
          rsp_valid_d = onehot(rr_ptr_q);
        end
`ifdef EXP_TIMEOUT_EN
        else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = S_DONE;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = onehot(rr_ptr_q);
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
    // Moore outputs follow the state being entered, so they are registered with it.
    busy_d       = (state_d != S_IDLE);
    exp_enable_d = (state_d == S_RUN);
  end

  // NOTE: sequential state uses non-blocking <= only; the combinational blocks above use blocking =.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: datapath flops are reset too, so an aborted job leaves every output at 0.
    if (!reset_n) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= IDX_W'(NUM_REQ - 1);
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      exp_x_q      <= '0;
      exp_enable_q <= 1'b0;
`ifdef EXP_TIMEOUT_EN
      tmo_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
      exp_x_q      <= exp_x_d;
      exp_enable_q <= exp_enable_d;
`ifdef EXP_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
`endif
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.busy       = busy_q;
  assign bus.exp_x      = exp_x_q;
  assign bus.exp_enable = exp_enable_q;

endmodule

// File: tb/tb_exp_unit_scheduler.sv
// Scoreboard bench for exp_unit_scheduler with a stub exponent unit (ack after 7 enabled edges).
// Directed stimulus pushes expected grants/responses; an independent monitor pops and compares.
module tb_exp_unit_scheduler;

  localparam int          DW = 32;
  localparam int          NR = 4;
  localparam logic [31:0] K  = 32'h00AD_F854;

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        err;
    int          lat;
  } rsp_t;

  logic clk;
  logic reset_n;
  logic stub_ack_en;
  logic [7:0] stub_cnt;
  int   cyc;
  int   last_ready_cyc;
  int   n_vec;
  int   n_miss;
  int   grant_q[$];
  rsp_t rsp_q[$];
  int   ready_cyc_q[$];

  exp_unit_scheduler_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  exp_unit_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT_CYCLES(15)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stub exponent unit: result = x + K, ack after 7 consecutive enabled edges.
  assign bus.exp_out = bus.exp_x + K;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stub_cnt    <= '0;
      bus.exp_ack <= 1'b0;
    end else if (!bus.exp_enable) begin
      stub_cnt    <= '0;
      bus.exp_ack <= 1'b0;
    end else begin
      if (stub_cnt != 8'hFF) stub_cnt <= stub_cnt + 8'd1;
      bus.exp_ack <= stub_ack_en && (stub_cnt >= 8'd6);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_job(input int idx, input logic [31:0] x);
    rsp_t r;
    r.idx  = idx;
    r.data = x + K;
    r.err  = 1'b0;
    r.lat  = 9;
    grant_q.push_back(idx);
    rsp_q.push_back(r);
  endtask

  task automatic set_req(input int idx, input logic [31:0] x);
    bus.req_x[idx*DW +: DW] = x;
    bus.req_valid[idx]      = 1'b1;
  endtask

  task automatic wait_ready(input int idx, input int budget);
    bit found;
    found = 1'b0;
    for (int c = 0; c < budget && !found; c++) begin
      @(negedge clk);
      if (bus.req_ready[idx]) found = 1'b1;
    end
    check($sformatf("ready%0d_wait", idx), found, 1);
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (!bus.busy && grant_q.size() == 0 && rsp_q.size() == 0) done = 1'b1;
    end
    check("idle_wait", done, 1);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("rst_exp_enable", bus.exp_enable, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_outputs", {bus.req_ready, bus.rsp_valid, bus.rsp_err}, 0);
    check("rst_data", {bus.exp_x, bus.rsp_data}, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a grant or a response.
  always @(negedge clk) begin
    rsp_t e;
    int   g;
    if (reset_n) begin
      if (bus.req_ready != '0) begin
        if (grant_q.size() == 0) begin
          check("ready_unexpected", bus.req_ready, 0);
        end else begin
          g = grant_q.pop_front();
          check("ready_idx", bus.req_ready, 64'(1) << g);
          last_ready_cyc = cyc;
          ready_cyc_q.push_back(cyc);
        end
      end
      if (bus.rsp_valid != '0) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", bus.rsp_valid, 0);
        end else begin
          e = rsp_q.pop_front();
          check("rsp_idx", bus.rsp_valid, 64'(1) << e.idx);
          check("rsp_data", bus.rsp_data, e.data);
          check("rsp_err", bus.rsp_err, e.err);
          check("rsp_latency", cyc - last_ready_cyc, e.lat);
        end
      end else begin
        check("rsp_err_idle", bus.rsp_err, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int   gap;
    bit   found;
    rsp_t r;
    n_vec = 0; n_miss = 0; cyc = 0; last_ready_cyc = 0;
    reset_n       = 1'b0;
    stub_ack_en   = 1'b1;
    bus.req_valid = '0;
    bus.req_x     = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_enable", bus.exp_enable, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_pulses", {bus.req_ready, bus.rsp_valid}, 0);
    check("reset_data", {bus.exp_x, bus.rsp_data}, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // 1: single request
    tick(1);
    grant_q.push_back(0);
    r.idx = 0; r.data = 32'h402D_F854; r.err = 1'b0; r.lat = 9;
    rsp_q.push_back(r);
    set_req(0, 32'h3F80_0000);
    wait_ready(0, 20);
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    check("exp_x_loaded", bus.exp_x, 32'h3F80_0000);
    wait_idle(40);
    tick(3);
    check("rsp_data_hold", bus.rsp_data, 32'h402D_F854);

    // 2: all four requesting continuously from reset
    reset_pulse();
    ready_cyc_q.delete();
    set_req(0, 32'h3F80_0000);
    set_req(1, 32'h4000_0000);
    set_req(2, 32'hBF80_0000);
    set_req(3, 32'h0000_0000);
    expect_job(0, 32'h3F80_0000);
    expect_job(1, 32'h4000_0000);
    expect_job(2, 32'hBF80_0000);
    expect_job(3, 32'h0000_0000);
    expect_job(0, 32'h3F80_0000);
    for (int i = 0; i < 4; i++) wait_ready(i, 20);
    wait_ready(0, 20);
    bus.req_valid = '0;
    wait_idle(40);
    check("b2b_count", ready_cyc_q.size(), 5);
    for (int i = 1; i < 5 && i < ready_cyc_q.size(); i++)
      check($sformatf("b2b_period%0d", i), ready_cyc_q[i] - ready_cyc_q[i-1], 10);

    // 3: request 2 raised during job 0's RUN is granted straight from DONE
    tick(1);
    expect_job(0, 32'h4040_0000);
    expect_job(2, 32'h3E80_0000);
    set_req(0, 32'h4040_0000);
    wait_ready(0, 20);
    bus.req_valid[0] = 1'b0;
    tick(3);
    set_req(2, 32'h3E80_0000);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (bus.rsp_valid[0]) found = 1'b1;
    end
    check("job0_rsp_seen", found, 1);
    gap = 0;
    while (!bus.exp_enable && gap < 20) begin
      gap++;
      @(negedge clk);
      if (gap == 1) begin
        check("no_idle_bubble", bus.req_ready, 4'b0100);
        bus.req_valid[2] = 1'b0;
      end
    end
    check("enable_gap", gap, 2);
    wait_idle(40);

    // 4: reset mid-RUN drops the job; pointer restarts at NUM_REQ-1
    tick(1);
    grant_q.push_back(1);
    set_req(1, 32'h4100_0000);
    wait_ready(1, 20);
    bus.req_valid[1] = 1'b0;
    tick(4);
    check("run_before_reset", bus.exp_enable, 1);
    reset_pulse();
    expect_job(0, 32'h4120_0000);
    expect_job(3, 32'h4140_0000);
    set_req(0, 32'h4120_0000);
    set_req(3, 32'h4140_0000);
    wait_ready(0, 20);
    bus.req_valid[0] = 1'b0;
    wait_ready(3, 20);
    bus.req_valid[3] = 1'b0;
    wait_idle(40);

    // 5: request 1 withdrawn before it is ever granted
    tick(1);
    expect_job(0, 32'h4160_0000);
    set_req(0, 32'h4160_0000);
    wait_ready(0, 20);
    bus.req_valid[0] = 1'b0;
    tick(2);
    set_req(1, 32'h4180_0000);
    tick(3);
    bus.req_valid[1] = 1'b0;
    wait_idle(40);
    tick(5);
    check("withdrawn_idle", bus.busy, 0);

    // 6: exponent unit never acks
    tick(1);
    stub_ack_en = 1'b0;
    grant_q.push_back(2);
    set_req(2, 32'h4190_0000);
`ifdef EXP_TIMEOUT_EN
    r.idx = 2; r.data = 32'h0; r.err = 1'b1; r.lat = 16;
    rsp_q.push_back(r);
    wait_ready(2, 20);
    bus.req_valid[2] = 1'b0;
    wait_idle(40);
    check("timeout_enable_low", bus.exp_enable, 0);
`else
    wait_ready(2, 20);
    bus.req_valid[2] = 1'b0;
    tick(40);
    check("stuck_run_busy", bus.busy, 1);
    check("stuck_run_enable", bus.exp_enable, 1);
    reset_pulse();
`endif
    stub_ack_en = 1'b1;
    tick(2);
    check("grant_q_empty", grant_q.size(), 0);
    check("rsp_q_empty", rsp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
